// File: rtl/rf_port_sequencer_pkg.sv
// Shared types for the register-file port sequencer: widths and the buffered
// writeback entry layout.
package rf_seq_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
    logic                 qed;
  } wb_entry_t;
endpackage

// File: rtl/rf_port_sequencer_if.sv
// Read-request/response and writeback handshakes between the pipeline (master)
// and the register-file port sequencer (slave).
interface rf_port_sequencer_if;
  import rf_seq_pkg::*;

  logic                 rreq_valid;
  logic                 rreq_ready;
  logic [REG_IDX_W-1:0] rreq_rs1i;
  logic [REG_IDX_W-1:0] rreq_rs2i;
  logic                 rrsp_valid;
  logic [XLEN-1:0]      rrsp_rs1;
  logic [XLEN-1:0]      rrsp_rs2;
  logic                 wreq_valid;
  logic                 wreq_ready;
  logic [REG_IDX_W-1:0] wreq_rdi;
  logic [XLEN-1:0]      wreq_rd;
  logic                 wreq_qed;

  modport master (
    output rreq_valid, rreq_rs1i, rreq_rs2i,
    output wreq_valid, wreq_rdi, wreq_rd, wreq_qed,
    input  rreq_ready, rrsp_valid, rrsp_rs1, rrsp_rs2, wreq_ready
  );

  modport slave (
    input  rreq_valid, rreq_rs1i, rreq_rs2i,
    input  wreq_valid, wreq_rdi, wreq_rd, wreq_qed,
    output rreq_ready, rrsp_valid, rrsp_rs1, rrsp_rs2, wreq_ready
  );
endinterface

// File: rtl/rf_port_sequencer_wb_fifo.sv
// Circular writeback buffer; every slot is visible so the parent can forward
// pending writes to reads.
module wb_fifo
  import rf_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output wb_entry_t        o_entries [DEPTH]
);
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_expose
    assign o_entries[gi] = r_mem[gi];
  end
endmodule

// File: rtl/rf_port_sequencer.sv
// Owns the register file's single read/write port: grants one read or one
// buffered writeback per cycle and forwards pending writes to reads.
module rf_port_sequencer
  import rf_seq_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_port_sequencer_if.slave   bus,
  output logic                 rf_rdw_rsrn,
  output logic [REG_IDX_W-1:0] rf_rdi,
  output logic [REG_IDX_W-1:0] rf_rs1i,
  output logic [REG_IDX_W-1:0] rf_rs2i,
  output logic [XLEN-1:0]      rf_rd,
  output logic                 rf_qed_vld_out_q,
  input  logic [XLEN-1:0]      rf_rs1,
  input  logic [XLEN-1:0]      rf_rs2,
  output logic                 wb_empty
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t            w_head;
  wb_entry_t            w_entries [WB_DEPTH];
  wb_entry_t            w_push_entry;
  logic                 w_full;
  logic                 w_empty;
  logic [PTR_W-1:0]     w_rd_ptr;
  logic [CNT_W-1:0]     w_count;
  logic                 w_ready;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_push;
  logic                 w_pop;
  logic                 r_rsp_valid;
  logic [REG_IDX_W-1:0] r_last_rs1i;
  logic [REG_IDX_W-1:0] r_last_rs2i;
  logic [REG_IDX_W-1:0] w_src_idx [2];
  logic [XLEN-1:0]      w_rf_data [2];
  logic [XLEN-1:0]      w_rsp_data [2];

  // Reads are refused while full so the drain path always wins the port.
  assign w_ready        = !w_full && !rst;
  assign bus.rreq_ready = w_ready;
  assign bus.wreq_ready = w_ready;
  assign w_rd_acc       = bus.rreq_valid && w_ready;
  assign w_wr_acc       = bus.wreq_valid && w_ready;
  assign w_push         = w_wr_acc && (bus.wreq_rdi != '0);
  assign w_pop          = !w_rd_acc && !w_empty;
  assign w_push_entry   = '{idx: bus.wreq_rdi, data: bus.wreq_rd, qed: bus.wreq_qed};

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_rd_ptr     (w_rd_ptr),
    .o_count      (w_count),
    .o_entries    (w_entries)
  );

  assign rf_rdw_rsrn      = w_pop;
  assign rf_rs1i          = w_rd_acc ? bus.rreq_rs1i : r_last_rs1i;
  assign rf_rs2i          = w_rd_acc ? bus.rreq_rs2i : r_last_rs2i;
  assign rf_rdi           = w_pop ? w_head.idx  : '0;
  assign rf_rd            = w_pop ? w_head.data : '0;
  assign rf_qed_vld_out_q = w_pop ? w_head.qed  : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_last_rs1i <= '0;
      r_last_rs2i <= '0;
    end else begin
      r_rsp_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_last_rs1i <= bus.rreq_rs1i;
        r_last_rs2i <= bus.rreq_rs2i;
      end
    end
  end

  assign w_src_idx[0] = bus.rreq_rs1i;
  assign w_src_idx[1] = bus.rreq_rs2i;
  assign w_rf_data[0] = rf_rs1;
  assign w_rf_data[1] = rf_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic            w_hit;
    logic [XLEN-1:0] w_hit_data;
    logic            r_hit;
    logic            r_zero;
    logic [XLEN-1:0] r_hit_data;

    // Scan oldest to youngest so the youngest matching entry overrides.
    always_comb begin
      logic [PTR_W-1:0] v_slot;
      v_slot     = '0;
      w_hit      = 1'b0;
      w_hit_data = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        v_slot = w_rd_ptr + PTR_W'(k);
        if ((CNT_W'(k) < w_count) && (w_entries[v_slot].idx == w_src_idx[gi])) begin
          w_hit      = 1'b1;
          w_hit_data = w_entries[v_slot].data;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hit      <= 1'b0;
        r_zero     <= 1'b0;
        r_hit_data <= '0;
      end else if (w_rd_acc) begin
        r_hit      <= w_hit;
        r_zero     <= (w_src_idx[gi] == '0);
        r_hit_data <= w_hit_data;
      end
    end

    assign w_rsp_data[gi] = (!r_rsp_valid || r_zero) ? '0 :
                            r_hit ? r_hit_data : w_rf_data[gi];
  end

  assign bus.rrsp_valid = r_rsp_valid;
  assign bus.rrsp_rs1   = w_rsp_data[0];
  assign bus.rrsp_rs2   = w_rsp_data[1];
  assign wb_empty       = w_empty && !r_rsp_valid;
endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench for rf_port_sequencer with a registered-read register file
// model; every expected value below is hand-computed.
module tb_rf_port_sequencer;
  import rf_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_rdw_rsrn;
  logic [4:0]  rf_rdi;
  logic [4:0]  rf_rs1i;
  logic [4:0]  rf_rs2i;
  logic [31:0] rf_rd;
  logic        rf_qed_vld_out_q;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic        wb_empty;

  logic [31:0] rf_mem [32];
  logic        init_done;
  int          wr_cnt;
  int          base_cnt;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  rf_port_sequencer_if bus();

  rf_port_sequencer #(.WB_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .rf_rdw_rsrn      (rf_rdw_rsrn),
    .rf_rdi           (rf_rdi),
    .rf_rs1i          (rf_rs1i),
    .rf_rs2i          (rf_rs2i),
    .rf_rd            (rf_rd),
    .rf_qed_vld_out_q (rf_qed_vld_out_q),
    .rf_rs1           (rf_rs1),
    .rf_rs2           (rf_rs2),
    .wb_empty         (wb_empty)
  );

  // Register file model: x0 holds a nonzero value so zero-forcing is visible.
  always @(posedge clk) begin
    if (init_done !== 1'b1) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + 32'(i);
      rf_mem[3] <= 32'hDEAD_BEEF;
      rf_mem[0] <= 32'hBAD0_0000;
      rf_rs1    <= '0;
      rf_rs2    <= '0;
      wr_cnt    <= 0;
      init_done <= 1'b1;
    end else if (rf_rdw_rsrn) begin
      rf_mem[rf_rdi] <= rf_rd;
      wr_cnt         <= wr_cnt + 1;
    end else begin
      rf_rs1 <= rf_mem[rf_rs1i];
      rf_rs2 <= rf_mem[rf_rs2i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rv, input int r1, input int r2,
                       input int wv, input int wi, input logic [31:0] wd, input int wq);
    bus.rreq_valid = 1'(rv);
    bus.rreq_rs1i  = 5'(r1);
    bus.rreq_rs2i  = 5'(r2);
    bus.wreq_valid = 1'(wv);
    bus.wreq_rdi   = 5'(wi);
    bus.wreq_rd    = wd;
    bus.wreq_qed   = 1'(wq);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    repeat (3) step();
    chk("rst_rrsp_valid", 32'(bus.rrsp_valid), 0);
    chk("rst_rrsp_rs1", bus.rrsp_rs1, 0);
    chk("rst_rdw", 32'(rf_rdw_rsrn), 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_rs1i", 32'(rf_rs1i), 0);
    chk("rst_wb_empty", 32'(wb_empty), 1);
    chk("rst_wready", 32'(bus.wreq_ready), 0);
    chk("rst_rready", 32'(bus.rreq_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rready", 32'(bus.rreq_ready), 1);

    // Idle read: x3 from the register file, x2-slot index 0 forced to zero.
    drive(1, 3, 0, 0, 0, 32'h0, 0);
    chk("idle_grant_read", 32'(rf_rdw_rsrn), 0);
    chk("idle_rs1i", 32'(rf_rs1i), 3);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("idle_rsp_valid", 32'(bus.rrsp_valid), 1);
    chk("idle_rsp_rs1", bus.rrsp_rs1, 32'hDEAD_BEEF);
    chk("idle_rsp_rs2", bus.rrsp_rs2, 0);
    step();
    chk("idle_rsp_pulse", 32'(bus.rrsp_valid), 0);
    chk("idle_hold_rs1i", 32'(rf_rs1i), 3);

    // Forwarding: two writes of x5 held in the FIFO by continuous reads.
    drive(1, 1, 2, 1, 5, 32'h11, 0);
    step();
    drive(1, 1, 2, 1, 5, 32'h22, 1);
    chk("fwd_b2b_valid", 32'(bus.rrsp_valid), 1);
    chk("fwd_b2b_rs1", bus.rrsp_rs1, 32'h1000_0001);
    step();
    drive(1, 5, 5, 0, 0, 32'h0, 0);
    chk("fwd_b2b_valid2", 32'(bus.rrsp_valid), 1);
    chk("fwd_read_blocks_write", 32'(rf_rdw_rsrn), 0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("fwd_rs1", bus.rrsp_rs1, 32'h22);
    chk("fwd_rs2", bus.rrsp_rs2, 32'h22);
    chk("fwd_drain0_rdw", 32'(rf_rdw_rsrn), 1);
    chk("fwd_drain0_rdi", 32'(rf_rdi), 5);
    chk("fwd_drain0_rd", rf_rd, 32'h11);
    chk("fwd_drain0_qed", 32'(rf_qed_vld_out_q), 0);
    step();
    chk("fwd_drain1_rd", rf_rd, 32'h22);
    chk("fwd_drain1_qed", 32'(rf_qed_vld_out_q), 1);
    step();
    chk("fwd_empty", 32'(wb_empty), 1);
    chk("fwd_committed", rf_mem[5], 32'h22);

    // Same-cycle push and read: the read sees the old value.
    drive(1, 7, 0, 1, 7, 32'h55, 0);
    chk("same_grant_read", 32'(rf_rdw_rsrn), 0);
    step();
    drive(1, 7, 7, 0, 0, 32'h0, 0);
    chk("same_old_val", bus.rrsp_rs1, 32'h1000_0007);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("same_next_rs1", bus.rrsp_rs1, 32'h55);
    chk("same_next_rs2", bus.rrsp_rs2, 32'h55);
    step();
    step();
    chk("same_committed", rf_mem[7], 32'h55);
    chk("same_empty", 32'(wb_empty), 1);

    // Full FIFO: four writes under continuous reads, then forced drain.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 2, 1, 8 + k, 32'(32'hA0 + k), (k % 2 == 0) ? 1 : 0);
      chk("full_fill_wready", 32'(bus.wreq_ready), 1);
      step();
    end
    drive(1, 1, 2, 0, 0, 32'h0, 0);
    chk("full_wready", 32'(bus.wreq_ready), 0);
    chk("full_rready", 32'(bus.rreq_ready), 0);
    chk("full_drain_rdw", 32'(rf_rdw_rsrn), 1);
    chk("full_drain_rdi", 32'(rf_rdi), 8);
    chk("full_drain_rd", rf_rd, 32'hA0);
    chk("full_drain_qed", 32'(rf_qed_vld_out_q), 1);
    step();
    chk("full_reopen", 32'(bus.rreq_ready), 1);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("full_drain2_rdi", 32'(rf_rdi), 9);
    chk("full_drain2_qed", 32'(rf_qed_vld_out_q), 0);
    repeat (3) step();
    chk("full_empty", 32'(wb_empty), 1);
    chk("full_committed", rf_mem[11], 32'hA3);

    // x0 write is dropped; x0 reads return zero.
    base_cnt = wr_cnt;
    drive(0, 0, 0, 1, 0, 32'hFFFF, 1);
    chk("x0_wready", 32'(bus.wreq_ready), 1);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("x0_no_write", 32'(rf_rdw_rsrn), 0);
    chk("x0_empty", 32'(wb_empty), 1);
    step();
    chk("x0_wr_cnt", 32'(wr_cnt), 32'(base_cnt));
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("x0_rsp_valid", 32'(bus.rrsp_valid), 1);
    chk("x0_rsp_rs1", bus.rrsp_rs1, 0);
    chk("x0_rsp_rs2", bus.rrsp_rs2, 0);

    // Reset with three buffered writes and a read in flight.
    drive(1, 1, 2, 1, 12, 32'hC0, 1);
    step();
    drive(1, 1, 2, 1, 13, 32'hC1, 0);
    step();
    drive(1, 12, 13, 1, 14, 32'hC2, 1);
    step();
    chk("mid_pre_valid", 32'(bus.rrsp_valid), 1);
    chk("mid_pre_empty", 32'(wb_empty), 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("mid_rst_valid", 32'(bus.rrsp_valid), 0);
    chk("mid_rst_wready", 32'(bus.wreq_ready), 0);
    repeat (2) step();
    base_cnt = wr_cnt;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_post_valid", 32'(bus.rrsp_valid), 0);
      chk("mid_post_rdw", 32'(rf_rdw_rsrn), 0);
    end
    chk("mid_wr_cnt", 32'(wr_cnt), 32'(base_cnt));
    chk("mid_empty", 32'(wb_empty), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_port_sequencer.md
# rf_port_sequencer

Sits directly upstream of the register file and owns its single shared port, whose `rdw_rsrn` select means a write cycle cannot also be a read cycle. It accepts read requests (rs1/rs2 index pairs) and writeback requests (rd index, data, QED-valid tag), buffers writebacks in a small FIFO, and drives the register file one operation per cycle. Reads see pending buffered writes through forwarding, so the result is as if every accepted write had already committed.

## Interface
- `WB_DEPTH`, 4: writeback FIFO entries; power of two, 2..16.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rreq_valid` / `rreq_ready`  in / out  1 / 1  read request handshake.
- `rreq_rs1i`, `rreq_rs2i`  in  5 each  source register indexes.
- `rrsp_valid`  out  1  read response pulse; there is no backpressure.
- `rrsp_rs1`, `rrsp_rs2`  out  32 each  read data.
- `wreq_valid` / `wreq_ready`  in / out  1 / 1  writeback handshake.
- `wreq_rdi`  in  5  destination register index.
- `wreq_rd`  in  32  writeback data.
- `wreq_qed`  in  1  QED-valid tag, carried with the entry.
- `rf_rdw_rsrn`  out  1  to the register file: 1 = write, 0 = read.
- `rf_rdi`, `rf_rs1i`, `rf_rs2i`  out  5 each  register file indexes.
- `rf_rd`  out  32  register file write data.
- `rf_qed_vld_out_q`  out  1  register file QED tag.
- `rf_rs1`, `rf_rs2`  in  32 each  register file read data; registered, one-cycle latency.
- `wb_empty`  out  1  FIFO empty and no read in flight.

## Operation
- A transfer occurs when valid and ready are both high in the same cycle.
- `wreq_ready` = FIFO not full.
- `rreq_ready` = FIFO not full. When the FIFO is full, writes drain first, which bounds starvation.
- Write handling:
  - An accepted write with `wreq_rdi` == 0 is dropped: it is not enqueued, it is not forwarded, and x0 stays 0.
  - Any other accepted write is enqueued.
- Grant, once per cycle:
  - If a read is accepted, drive `rf_rdw_rsrn`=0 and `rf_rs1i`/`rf_rs2i` = the request indexes.
  - Otherwise, if the FIFO is not empty, pop the head and drive `rf_rdw_rsrn`=1 with `rf_rdi`/`rf_rd`/`rf_qed_vld_out_q` = the head fields.
  - Otherwise (idle), hold `rf_rdw_rsrn`=0 and hold the last read indexes stable.
- Forwarding, evaluated in the grant cycle against the FIFO contents before that cycle's push:
  - For each source, the youngest matching entry wins.
  - A write pushed in the same cycle as a read is not visible to that read, because the read is ordered before the write.
  - Per source, register a hit flag and the hit data. At response time, select the hit data when the flag is set, otherwise `rf_rs1`/`rf_rs2`.
  - Index 0 always returns 0.
- FIFO: circular buffer with wrap-around pointers and a count register. A simultaneous push and pop when full is not possible, because ready is low when full. Push and pop in the same cycle are allowed otherwise.

## Timing
- Read latency:
  - Cycle t: handshake.
  - Cycle t+1: `rrsp_valid`=1 with the data.
  - Back-to-back reads give one response per cycle.
- Write: earliest issue to the register file is the cycle after acceptance.
- Reset values: `rrsp_valid`=0, `rrsp_rs*`=0, `rf_rdw_rsrn`=0, `rf_*i`=0, `rf_rd`=0, `rf_qed_vld_out_q`=0, FIFO empty, `wb_empty`=1.
- The ready signals are low while `rst` is asserted.
- Reset mid-operation: buffered writes are discarded and any in-flight response is dropped (no `rrsp_valid` after reset).
- `rf_rdw_rsrn` is registered-free combinational from the grant decision. `rf_*` outputs must not glitch to write while a read is granted.

## Structure
- Package `rf_seq_pkg`:
  - `XLEN`=32, `REG_IDX_W`=5.
  - typedef `wb_entry_t` {idx[4:0], data[31:0], qed}.
- One sub-module, `wb_fifo`: parameterised depth. It exposes all entries read-only for forwarding (youngest-first priority is computed in the parent).
- The grant and forwarding logic live in the top module.

## Test plan
- Idle read: after reset, read rs1i=3, rs2i=0 with a register file model returning 0xDEAD_BEEF → at t+1, `rrsp_rs1`=0xDEAD_BEEF, `rrsp_rs2`=0.
- Forwarding: write x5=0x11, then x5=0x22, with reads asserted so the FIFO holds both; read rs1i=5 → response 0x22, and `rf_rs1` is ignored.
- Same-cycle push and read: read x7 in the same cycle as a write of x7=0x55 → response is the old register file value; a read of x7 the next cycle → 0x55.
- Full FIFO: 4 writes with continuous reads → `wreq_ready`=`rreq_ready`=0; the next cycle drains a write with `rf_rdw_rsrn`=1 and `rf_qed_vld_out_q` = the entry tag.
- x0 write: write x0=0xFFFF → no `rf_rdw_rsrn` pulse; a read of x0 returns 0.
- Reset mid-stream: assert `rst` with 3 entries buffered and a read in flight → no response, no register file write after deassert, `wb_empty`=1.
